// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory.
// One transaction is in flight at a time: IDLE -> WR -> IDLE, or IDLE -> RD -> RESP -> IDLE.
module mem_arbiter #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [1:0]        req_wr,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [ADDR_W-1:0] req_addr1,
   input  logic [DATA_W-1:0] req_wdata0,
   input  logic [DATA_W-1:0] req_wdata1,
   output logic [1:0]        rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              mem_wr,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_index_wr,
   output logic [ADDR_W-1:0] mem_index_rd,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {StIdle, StWr, StRd, StResp} state_e;

   state_e              state_q, state_d;
   logic                last_grant_q, last_grant_d;
   logic                id_q, id_d;
   logic                wr_q, wr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                win;
   logic                accept;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      id_d         = id_q;
      wr_d         = wr_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      req_ready    = 2'b00;
      rsp_valid    = 2'b00;
      mem_wr       = 1'b0;
      mem_rd       = 1'b0;
      mem_index_wr = '0;
      mem_index_rd = '0;
      mem_wdata    = '0;

      // With both requesting, the one not granted last wins; otherwise the sole requester.
      win    = (&req_valid) ? ~last_grant_q : req_valid[1];
      accept = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (rst_n && (|req_valid)) begin
               req_ready    = win ? 2'b10 : 2'b01;
               accept       = 1'b1;
               last_grant_d = win;
               id_d         = win;
               wr_d         = req_wr[win];
               addr_d       = win ? req_addr1 : req_addr0;
               wdata_d      = win ? req_wdata1 : req_wdata0;
               state_d      = req_wr[win] ? StWr : StRd;
            end
         end
         StWr: begin
            mem_wr       = rst_n;
            mem_index_wr = addr_q;
            mem_wdata    = wdata_q;
            state_d      = StIdle;
         end
         StRd: begin
            mem_rd       = rst_n;
            mem_index_rd = addr_q;
            rdata_d      = mem_rdata;
            state_d      = StResp;
         end
         StResp: begin
            if (rst_n) begin
               rsp_valid = id_q ? 2'b10 : 2'b01;
            end
            state_d = StIdle;
         end
      endcase
   end

   assign rsp_rdata = rdata_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         wr_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         wr_q         <= wr_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected grants, writes, reads and
// responses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_arbiter;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 2;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   typedef struct packed {
      logic              id;
      logic [DATA_W-1:0] data;
   } rsp_t;

   logic              clk;
   logic              rst_n;
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [1:0]        req_wr;
   logic [ADDR_W-1:0] req_addr0;
   logic [ADDR_W-1:0] req_addr1;
   logic [DATA_W-1:0] req_wdata0;
   logic [DATA_W-1:0] req_wdata1;
   logic [1:0]        rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              mem_wr;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_index_wr;
   logic [ADDR_W-1:0] mem_index_rd;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic [DATA_W-1:0] mem [16];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic              exp_grant_q [$];
   wr_t               exp_wr_q    [$];
   logic [ADDR_W-1:0] exp_rd_q    [$];
   rsp_t              exp_rsp_q   [$];
   int                acc_log     [$];

   mem_arbiter #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_wr      (req_wr),
      .req_addr0   (req_addr0),
      .req_addr1   (req_addr1),
      .req_wdata0  (req_wdata0),
      .req_wdata1  (req_wdata1),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .mem_wr      (mem_wr),
      .mem_rd      (mem_rd),
      .mem_index_wr(mem_index_wr),
      .mem_index_rd(mem_index_rd),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: synchronous write, combinational read while mem_rd is high.
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = '0;
   end
   always @(posedge clk) begin
      if (mem_wr) mem[mem_index_wr] <= mem_wdata;
   end
   assign mem_rdata = mem_rd ? mem[mem_index_rd] : '0;

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: one pass per cycle, away from the active edge.
   always @(negedge clk) begin
      logic [1:0] hs;
      logic [1:0] want;
      logic       g;
      wr_t        w;
      rsp_t       r;
      logic [ADDR_W-1:0] ra;
      int         last_acc;
      cyc++;
      last_acc = (acc_log.size() > 0) ? acc_log[$] : -100;
      hs = req_valid & req_ready;
      if (hs != 2'b00) begin
         if (exp_grant_q.size() == 0) begin
            chk(1'b0, "unexpected_accept", int'(hs), 0);
         end else begin
            g    = exp_grant_q.pop_front();
            want = g ? 2'b10 : 2'b01;
            chk(hs == want, "grant", int'(hs), int'(want));
         end
         if (acc_log.size() > 0) chk(cyc - last_acc >= 2, "accept_spacing", cyc - last_acc, 2);
         acc_log.push_back(cyc);
      end
      if (mem_wr) begin
         if (exp_wr_q.size() == 0) begin
            chk(1'b0, "unexpected_mem_wr", 1, 0);
         end else begin
            w = exp_wr_q.pop_front();
            chk(mem_index_wr == w.addr, "mem_index_wr", int'(mem_index_wr), int'(w.addr));
            chk(mem_wdata == w.data, "mem_wdata", int'(mem_wdata), int'(w.data));
            chk(cyc == last_acc + 1, "wr_latency", cyc - last_acc, 1);
         end
      end
      if (mem_rd) begin
         if (exp_rd_q.size() == 0) begin
            chk(1'b0, "unexpected_mem_rd", 1, 0);
         end else begin
            ra = exp_rd_q.pop_front();
            chk(mem_index_rd == ra, "mem_index_rd", int'(mem_index_rd), int'(ra));
            chk(cyc == last_acc + 1, "rd_latency", cyc - last_acc, 1);
         end
      end
      if (rsp_valid != 2'b00) begin
         if (exp_rsp_q.size() == 0) begin
            chk(1'b0, "unexpected_rsp", int'(rsp_valid), 0);
         end else begin
            r    = exp_rsp_q.pop_front();
            want = r.id ? 2'b10 : 2'b01;
            chk(rsp_valid == want, "rsp_valid", int'(rsp_valid), int'(want));
            chk(rsp_rdata == r.data, "rsp_rdata", int'(rsp_rdata), int'(r.data));
            chk(cyc == last_acc + 2, "rsp_latency", cyc - last_acc, 2);
         end
      end
      if (mem_wr && mem_rd) chk(1'b0, "wr_rd_overlap", 1, 0);
      if (rst_n && !mem_wr && (mem_index_wr != '0 || mem_wdata != '0))
         chk(1'b0, "wr_bus_idle_zero", int'({mem_index_wr, mem_wdata}), 0);
      if (rst_n && !mem_rd && mem_index_rd != '0)
         chk(1'b0, "rd_bus_idle_zero", int'(mem_index_rd), 0);
   end

   // Entered just after a rising edge; returns just after the accepting edge.
   task automatic issue(input logic id, input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] exp_rd,
                        input bit expect_mem);
      bit ok;
      exp_grant_q.push_back(id);
      if (expect_mem) begin
         if (wr) begin
            exp_wr_q.push_back(wr_t'{addr, wd});
         end else begin
            exp_rd_q.push_back(addr);
            exp_rsp_q.push_back(rsp_t'{id, exp_rd});
         end
      end
      req_wr[id] = wr;
      if (id) begin
         req_addr1  = addr;
         req_wdata1 = wd;
      end else begin
         req_addr0  = addr;
         req_wdata0 = wd;
      end
      req_valid[id] = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = req_ready[id];
      end
      if (!ok) chk(1'b0, "accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      req_valid[id] = 1'b0;
   endtask

   task automatic idle_wait();
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 2'b11;
      req_wr     = 2'b11;
      req_addr0  = 4'd0;
      req_wdata0 = 2'd1;
      req_addr1  = 4'd1;
      req_wdata1 = 2'd2;

      // Reset with both requesting: nothing may be granted or driven.
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         chk(req_ready == 2'b00, "reset_ready", int'(req_ready), 0);
         chk(!mem_wr && !mem_rd, "reset_mem_en", int'({mem_wr, mem_rd}), 0);
         chk(rsp_valid == 2'b00, "reset_rsp_valid", int'(rsp_valid), 0);
         chk(rsp_rdata == 2'b00, "reset_rsp_rdata", int'(rsp_rdata), 0);
      end
      exp_grant_q.push_back(1'b0);
      exp_wr_q.push_back(wr_t'{4'd0, 2'd1});
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk(req_ready == 2'b01, "first_grant_after_reset", int'(req_ready), 1);
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      idle_wait();

      // Write from requester 0; no grant during the WR cycle.
      issue(1'b0, 1'b1, 4'd5, 2'b10, 2'b00, 1'b1);
      @(negedge clk);
      chk(req_ready == 2'b00, "ready_in_wr", int'(req_ready), 0);
      idle_wait();

      // Read-back of the same index by requester 1.
      issue(1'b1, 1'b0, 4'd5, 2'b00, 2'b10, 1'b1);
      idle_wait();

      // Contention: last grant was 1, so grants run 0,1,0,1.
      exp_grant_q.push_back(1'b0);
      exp_wr_q.push_back(wr_t'{4'd2, 2'd1});
      exp_grant_q.push_back(1'b1);
      exp_wr_q.push_back(wr_t'{4'd3, 2'd3});
      exp_grant_q.push_back(1'b0);
      exp_wr_q.push_back(wr_t'{4'd2, 2'd1});
      exp_grant_q.push_back(1'b1);
      exp_wr_q.push_back(wr_t'{4'd3, 2'd3});
      req_wr     = 2'b11;
      req_addr0  = 4'd2;
      req_wdata0 = 2'd1;
      req_addr1  = 4'd3;
      req_wdata1 = 2'd3;
      req_valid  = 2'b11;
      repeat (8) @(negedge clk);
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      idle_wait();

      // Top index, write then read back-to-back from requester 1.
      issue(1'b1, 1'b1, 4'd15, 2'b11, 2'b00, 1'b1);
      issue(1'b1, 1'b0, 4'd15, 2'b00, 2'b11, 1'b1);
      if (acc_log.size() >= 2)
         chk(acc_log[$] - acc_log[$-1] == 2, "b2b_accept_gap", acc_log[$] - acc_log[$-1], 2);
      else
         chk(1'b0, "b2b_accept_count", acc_log.size(), 2);
      idle_wait();
      @(negedge clk);
      chk(rsp_rdata == 2'b11, "rdata_hold", int'(rsp_rdata), 3);
      @(posedge clk);
      #1;

      // Abort: reset during the RD cycle of a read to index 3 (which holds 3).
      issue(1'b0, 1'b0, 4'd3, 2'b00, 2'b00, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      chk(!mem_rd, "abort_mem_rd", int'(mem_rd), 0);
      chk(rsp_valid == 2'b00, "abort_rsp_in_rd", int'(rsp_valid), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_grant_q.push_back(1'b1);
      exp_wr_q.push_back(wr_t'{4'd7, 2'd1});
      req_wr[1]  = 1'b1;
      req_addr1  = 4'd7;
      req_wdata1 = 2'd1;
      req_valid  = 2'b10;
      @(negedge clk);
      chk(rsp_valid == 2'b00, "abort_no_rsp", int'(rsp_valid), 0);
      chk(rsp_rdata == 2'b00, "abort_rdata_cleared", int'(rsp_rdata), 0);
      chk(req_ready == 2'b10, "idle_after_abort", int'(req_ready), 2);
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      idle_wait();

      issue(1'b0, 1'b0, 4'd7, 2'b00, 2'b01, 1'b1);
      idle_wait();
      repeat (2) @(posedge clk);

      chk(exp_grant_q.size() == 0, "grants_left", exp_grant_q.size(), 0);
      chk(exp_wr_q.size() == 0, "writes_left", exp_wr_q.size(), 0);
      chk(exp_rd_q.size() == 0, "reads_left", exp_rd_q.size(), 0);
      chk(exp_rsp_q.size() == 0, "rsps_left", exp_rsp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
